// File: rtl/issue_ctrl_if.sv
// Instruction-buffer / issue-controller handshake bundle.
// The master side is the buffer and the branch/back-pressure sources; issue_ctrl is the slave.
interface issue_ctrl_if;
   logic        flush;
   logic        stall;
   logic        valid1;
   logic [31:0] inst1;
   logic        valid2;
   logic [31:0] inst2;
   logic        launch1;
   logic        launch2;
   logic [31:0] sb_busy;

   modport master (
      output flush, stall, valid1, inst1, valid2, inst2,
      input  launch1, launch2, sb_busy
   );

   modport slave (
      input  flush, stall, valid1, inst1, valid2, inst2,
      output launch1, launch2, sb_busy
   );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler with a load-use scoreboard of per-register down-counters.
// Optional ISSUE_STAT_EN adds dual/single/hazard cycle counters as outputs.
module issue_ctrl #(
   parameter int LOAD_LAT = 2,
   parameter int DUAL_EN  = 1
) (
   input  logic         clk,
   input  logic         rst,
   issue_ctrl_if.slave  bus
`ifdef ISSUE_STAT_EN
   ,
   output logic [31:0]  stat_dual,
   output logic [31:0]  stat_single,
   output logic [31:0]  stat_hazard
`endif
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_SYS    = 7'b1110011;
   localparam logic [1:0] LAT       = 2'(LOAD_LAT);

   logic [6:0]  w_op1, w_op2;
   logic [4:0]  w_rd1, w_rs1_1, w_rs2_1, w_rd2, w_rs1_2, w_rs2_2;
   logic        w_use1_1, w_use2_1, w_wr1, w_mem1, w_ctrl1, w_sys1;
   logic        w_use1_2, w_use2_2, w_wr2, w_mem2, w_sys2;
   logic        w_haz1, w_haz2, w_raw, w_waw;
   logic        w_launch1, w_launch2, w_ld1, w_ld2;
   logic [31:0] w_busy;
   logic [1:0]  r_cnt [31:1];
   logic        w_unused;

   assign w_op1   = bus.inst1[6:0];
   assign w_rd1   = bus.inst1[11:7];
   assign w_rs1_1 = bus.inst1[19:15];
   assign w_rs2_1 = bus.inst1[24:20];
   assign w_op2   = bus.inst2[6:0];
   assign w_rd2   = bus.inst2[11:7];
   assign w_rs1_2 = bus.inst2[19:15];
   assign w_rs2_2 = bus.inst2[24:20];
   assign w_unused = &{1'b0, bus.inst1[31:25], bus.inst1[14:12],
                       bus.inst2[31:25], bus.inst2[14:12]};

   assign w_use1_1 = !(w_op1 == OP_LUI || w_op1 == OP_AUIPC || w_op1 == OP_JAL);
   assign w_use2_1 = (w_op1 == OP_OP || w_op1 == OP_STORE || w_op1 == OP_BRANCH);
   assign w_wr1    = !(w_op1 == OP_STORE || w_op1 == OP_BRANCH) && (w_rd1 != 5'd0);
   assign w_mem1   = (w_op1 == OP_LOAD || w_op1 == OP_STORE);
   assign w_ctrl1  = (w_op1 == OP_BRANCH || w_op1 == OP_JAL || w_op1 == OP_JALR);
   assign w_sys1   = (w_op1 == OP_SYS);

   assign w_use1_2 = !(w_op2 == OP_LUI || w_op2 == OP_AUIPC || w_op2 == OP_JAL);
   assign w_use2_2 = (w_op2 == OP_OP || w_op2 == OP_STORE || w_op2 == OP_BRANCH);
   assign w_wr2    = !(w_op2 == OP_STORE || w_op2 == OP_BRANCH) && (w_rd2 != 5'd0);
   assign w_mem2   = (w_op2 == OP_LOAD || w_op2 == OP_STORE);
   assign w_sys2   = (w_op2 == OP_SYS);

   assign w_busy[0] = 1'b0;
   for (genvar g = 1; g < 32; g++) begin : g_busy
      assign w_busy[g] = (r_cnt[g] != 2'd0);
   end

   assign w_haz1 = (w_use1_1 && w_busy[w_rs1_1]) || (w_use2_1 && w_busy[w_rs2_1]);
   assign w_haz2 = (w_use1_2 && w_busy[w_rs1_2]) || (w_use2_2 && w_busy[w_rs2_2]);
   assign w_raw  = w_wr1 && ((w_use1_2 && w_rs1_2 == w_rd1) || (w_use2_2 && w_rs2_2 == w_rd1));
   assign w_waw  = w_wr1 && w_wr2 && (w_rd1 == w_rd2);

   assign w_launch1 = !rst && !bus.flush && !bus.stall && bus.valid1 && !w_haz1;
   // A control-flow op in slot 1 ends the pair; only one LSU so no MEM+MEM pairs.
   assign w_launch2 = (DUAL_EN != 0) && w_launch1 && bus.valid2 && !w_haz2 && !w_raw
                      && !w_waw && !(w_mem1 && w_mem2) && !w_ctrl1 && !w_sys1 && !w_sys2;

   assign w_ld1 = w_launch1 && (w_op1 == OP_LOAD);
   assign w_ld2 = w_launch2 && (w_op2 == OP_LOAD);

   assign bus.launch1 = w_launch1;
   assign bus.launch2 = w_launch2;
   assign bus.sb_busy = w_busy;

   // x0 has no counter, so loads to x0 can never mark the scoreboard.
   for (genvar g = 1; g < 32; g++) begin : g_cnt
      always_ff @(posedge clk) begin
         if (rst)
            r_cnt[g] <= 2'd0;
         else if ((w_ld1 && w_rd1 == 5'(g)) || (w_ld2 && w_rd2 == 5'(g)))
            r_cnt[g] <= LAT;
         else if (r_cnt[g] != 2'd0)
            r_cnt[g] <= r_cnt[g] - 2'd1;
      end
   end

`ifdef ISSUE_STAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_dual   <= 32'd0;
         stat_single <= 32'd0;
         stat_hazard <= 32'd0;
      end else begin
         if (w_launch2)
            stat_dual <= stat_dual + 32'd1;
         if (w_launch1 && !w_launch2)
            stat_single <= stat_single + 32'd1;
         if (bus.valid1 && !bus.stall && !bus.flush && !w_launch1)
            stat_hazard <= stat_hazard + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed + randomized bench for issue_ctrl; reference model tracks the cycle each register becomes readable.
module tb_issue_ctrl;
   localparam int LAT = 2;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_SYS    = 7'b1110011;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   issue_ctrl_if bus();

`ifdef ISSUE_STAT_EN
   logic [31:0] stat_dual, stat_single, stat_hazard;
   int unsigned m_dual, m_single, m_haz;
`endif

   issue_ctrl #(.LOAD_LAT(LAT), .DUAL_EN(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ISSUE_STAT_EN
      ,
      .stat_dual   (stat_dual),
      .stat_single (stat_single),
      .stat_hazard (stat_hazard)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int ready_at [32];
   logic        e_l1, e_l2;
   logic [31:0] e_busy;

   function automatic logic [31:0] enc(logic [6:0] op, int rd, int rs1, int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
   endfunction

   function automatic logic m_busy(int r);
      return (r != 0) && (cyc < ready_at[r]);
   endfunction

   function automatic logic reads_rs1(logic [31:0] i);
      return !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
   endfunction

   function automatic logic reads_rs2(logic [31:0] i);
      return i[6:0] inside {OP_OP, OP_STORE, OP_BRANCH};
   endfunction

   function automatic logic reads_reg(logic [31:0] i, int r);
      return (reads_rs1(i) && int'(i[19:15]) == r) || (reads_rs2(i) && int'(i[24:20]) == r);
   endfunction

   // Destination register actually written, 0 when none.
   function automatic int dest(logic [31:0] i);
      if (i[6:0] inside {OP_STORE, OP_BRANCH}) return 0;
      return int'(i[11:7]);
   endfunction

   function automatic logic blocked(logic [31:0] i);
      return (reads_rs1(i) && m_busy(int'(i[19:15]))) || (reads_rs2(i) && m_busy(int'(i[24:20])));
   endfunction

   function automatic logic is_mem(logic [31:0] i);
      return i[6:0] inside {OP_LOAD, OP_STORE};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(string tag, logic r, logic f, logic s,
                       logic v1, logic [31:0] i1, logic v2, logic [31:0] i2);
      @(negedge clk);
      rst = r; bus.flush = f; bus.stall = s;
      bus.valid1 = v1; bus.inst1 = i1; bus.valid2 = v2; bus.inst2 = i2;
      #1;
      e_l1 = !r && !f && !s && v1 && !blocked(i1);
      e_l2 = e_l1 && v2 && !blocked(i2)
             && !(dest(i1) != 0 && reads_reg(i2, dest(i1)))
             && !(dest(i1) != 0 && dest(i1) == dest(i2))
             && !(is_mem(i1) && is_mem(i2))
             && !(i1[6:0] inside {OP_BRANCH, OP_JAL, OP_JALR})
             && (i1[6:0] != OP_SYS) && (i2[6:0] != OP_SYS);
      for (int k = 0; k < 32; k++) e_busy[k] = m_busy(k);
      check({tag, "_l1"}, {31'b0, bus.launch1}, {31'b0, e_l1});
      check({tag, "_l2"}, {31'b0, bus.launch2}, {31'b0, e_l2});
      check({tag, "_busy"}, bus.sb_busy, e_busy);
      if (r) begin
         for (int k = 0; k < 32; k++) ready_at[k] = 0;
      end else begin
         if (e_l1 && i1[6:0] == OP_LOAD && i1[11:7] != 5'd0) ready_at[i1[11:7]] = cyc + LAT + 1;
         if (e_l2 && i2[6:0] == OP_LOAD && i2[11:7] != 5'd0) ready_at[i2[11:7]] = cyc + LAT + 1;
      end
`ifdef ISSUE_STAT_EN
      if (r) begin
         m_dual = 0; m_single = 0; m_haz = 0;
      end else begin
         if (e_l2) m_dual++;
         if (e_l1 && !e_l2) m_single++;
         if (v1 && !s && !f && !e_l1) m_haz++;
      end
`endif
      cyc++;
   endtask

   logic [6:0] ops [10];
   logic [31:0] ri1, ri2;

   initial begin
      for (int k = 0; k < 32; k++) ready_at[k] = 0;
      rst = 1'b1; bus.flush = 1'b0; bus.stall = 1'b0;
      bus.valid1 = 1'b0; bus.valid2 = 1'b0; bus.inst1 = '0; bus.inst2 = '0;
      ops = '{OP_OP, OP_IMM, OP_LOAD, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_SYS};

      step("rst", 1, 0, 0, 1, enc(OP_OP, 1, 2, 3), 1, enc(OP_OP, 4, 5, 6));
      check("rst_busy_zero", bus.sb_busy, 32'h0);
      step("indep", 0, 0, 0, 1, enc(OP_OP, 1, 2, 3), 1, enc(OP_OP, 4, 5, 6));
      check("indep_l2", {31'b0, bus.launch2}, 32'd1);
      step("raw", 0, 0, 0, 1, enc(OP_OP, 1, 2, 3), 1, enc(OP_OP, 4, 1, 5));
      check("raw_l2", {31'b0, bus.launch2}, 32'd0);
      step("lw7", 0, 0, 0, 1, enc(OP_LOAD, 7, 2, 0), 0, '0);
      step("use7_c1", 0, 0, 0, 1, enc(OP_OP, 8, 7, 1), 0, '0);
      check("use7_c1_bit7", {31'b0, bus.sb_busy[7]}, 32'd1);
      step("use7_c2", 0, 0, 0, 1, enc(OP_OP, 8, 7, 1), 0, '0);
      check("use7_c2_l1", {31'b0, bus.launch1}, 32'd0);
      step("use7_c3", 0, 0, 0, 1, enc(OP_OP, 8, 7, 1), 0, '0);
      check("use7_c3_l1", {31'b0, bus.launch1}, 32'd1);
      step("lw_sw", 0, 0, 0, 1, enc(OP_LOAD, 3, 2, 0), 1, enc(OP_STORE, 0, 2, 4));
      step("beq_add", 0, 0, 0, 1, enc(OP_BRANCH, 0, 10, 11), 1, enc(OP_OP, 12, 13, 14));
      step("add_beq", 0, 0, 0, 1, enc(OP_OP, 12, 13, 14), 1, enc(OP_BRANCH, 0, 10, 11));
      check("add_beq_l2", {31'b0, bus.launch2}, 32'd1);
      step("flush", 0, 1, 0, 1, enc(OP_OP, 1, 2, 3), 1, enc(OP_OP, 4, 5, 6));
      step("stall", 0, 0, 1, 1, enc(OP_OP, 1, 2, 3), 1, enc(OP_OP, 4, 5, 6));
      step("lw9", 0, 0, 0, 1, enc(OP_LOAD, 9, 2, 0), 0, '0);
      step("fl9_a", 0, 1, 0, 1, enc(OP_OP, 1, 2, 3), 0, '0);
      step("fl9_b", 0, 1, 0, 1, enc(OP_OP, 1, 2, 3), 0, '0);
      step("fl9_c", 0, 1, 0, 1, enc(OP_OP, 1, 2, 3), 0, '0);
      check("fl9_c_bit9", {31'b0, bus.sb_busy[9]}, 32'd0);
      step("lw5", 0, 0, 0, 1, enc(OP_LOAD, 5, 2, 0), 0, '0);
      step("rst_mid", 1, 0, 0, 1, enc(OP_OP, 6, 5, 1), 0, '0);
      step("after_rst", 0, 0, 0, 1, enc(OP_OP, 6, 5, 1), 0, '0);
      check("after_rst_l1", {31'b0, bus.launch1}, 32'd1);
      step("lw0", 0, 0, 0, 1, enc(OP_LOAD, 0, 2, 0), 0, '0);
      step("lw0_next", 0, 0, 0, 0, '0, 0, '0);
      check("lw0_busy", bus.sb_busy, 32'h0);
      step("v2_only", 0, 0, 0, 0, enc(OP_OP, 1, 2, 3), 1, enc(OP_OP, 4, 5, 6));

      for (int n = 0; n < 400; n++) begin
         ri1 = $urandom;
         ri2 = $urandom;
         ri1[6:0] = ops[$urandom_range(0, 9)];
         ri2[6:0] = ops[$urandom_range(0, 9)];
         ri1[11:7] = 5'($urandom_range(0, 7)); ri1[19:15] = 5'($urandom_range(0, 7));
         ri1[24:20] = 5'($urandom_range(0, 7));
         ri2[11:7] = 5'($urandom_range(0, 7)); ri2[19:15] = 5'($urandom_range(0, 7));
         ri2[24:20] = 5'($urandom_range(0, 7));
         step("rnd", ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
              ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 90), ri1,
              ($urandom_range(0, 99) < 80), ri2);
      end

`ifdef ISSUE_STAT_EN
      @(negedge clk);
      check("stat_dual", stat_dual, m_dual);
      check("stat_single", stat_single, m_single);
      check("stat_hazard", stat_hazard, m_haz);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Dual-issue scheduler between the instruction buffer and the decode/execute stages.
- Inspects the two head instructions the buffer presents and decides each cycle how many issue: 0, 1 or 2.
- Drives the buffer's launch flags. Keeps an internal load-use scoreboard so dependent instructions wait for load data.

Parameters:
- LOAD_LAT, 2, cycles a load's rd stays busy after issue (legal 1..3; counter width 2 bits).
- DUAL_EN, 1, 1 = slot 2 may issue; 0 = at most one instruction per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  branch mispredict; no issue this cycle.
- stall  in  1  downstream back-pressure; no issue this cycle.
- valid1  in  1  head instruction present (buffer sendout flag 1).
- inst1  in  32  head instruction word.
- valid2  in  1  second instruction present (buffer sendout flag 2).
- inst2  in  32  second instruction word.
- launch1  out  1  slot 1 issues this cycle.
- launch2  out  1  slot 2 issues this cycle; never 1 unless launch1 is 1.
- sb_busy  out  32  scoreboard busy vector; bit n = x[n] pending load.

Behaviour:
- Decode uses RV32I fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Uses rs1: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111.
- Uses rs2: OP 0110011, STORE 0100011, BRANCH 1100011.
- Writes rd: every opcode except STORE and BRANCH, and only when rd != 0.
- MEM: LOAD 0000011 or STORE. CTRL: BRANCH, JAL, JALR 1100111. SYS: 1110011.
- Scoreboard: 32 two-bit counters cnt[n]. cnt[0] is hardwired to 0. Hazard on a source register when cnt[rs] != 0.
- launch1 and launch2 are combinational from current inputs and scoreboard state. Latency 0, so the buffer samples them on the same posedge.
- launch1 = !rst & !flush & !stall & valid1 & no scoreboard hazard on inst1's used sources.
- launch2 = DUAL_EN & launch1 & valid2 & all of:
  - no scoreboard hazard on inst2's used sources.
  - no RAW: inst1 writes rd and inst2 uses that rd as rs1 or rs2.
  - no WAW: both instructions write the same rd.
  - not both MEM (single LSU).
  - inst1 not CTRL (a branch must be the last instruction of a pair).
  - neither instruction is SYS.
- Counter update each posedge, in priority order:
  1. rst: all cnt = 0.
  2. A load issued in a slot with rd != 0 sets cnt[rd] = LOAD_LAT. If both slots issue loads to the same rd this is impossible (WAW rule).
  3. Otherwise a nonzero cnt decrements by 1.
- Set wins over decrement for the same register in the same cycle.
- flush does not clear counters: loads already issued still complete.
- sb_busy[n] = (cnt[n] != 0), combinational.
- Reset values: all cnt = 0, sb_busy = 0, launch1 = launch2 = 0 while rst is high.
- Reset mid-operation: counters clear on that posedge; the next cycle issues freely.
- Boundaries:
  - valid1 = 0 with valid2 = 1 gives no issue (in-order).
  - Instructions with rd = 0 never mark the scoreboard.
  - LOAD_LAT = 1: dependent may issue two cycles after the load.

Optional Feature:
- Macro: ISSUE_STAT_EN.
- When defined, adds three 32-bit counters, each cleared by rst, wrapping at 2^32 and exposed as outputs:
  - stat_dual: cycles with launch2 = 1.
  - stat_single: cycles with launch1 = 1 and launch2 = 0.
  - stat_hazard: cycles with valid1 = 1, !stall, !flush and launch1 = 0.
- When undefined, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
- Independent ADDs, inst1 = add x1,x2,x3 and inst2 = add x4,x5,x6, both valid -> launch1 = 1, launch2 = 1.
- RAW pair, inst1 = add x1,x2,x3 and inst2 = sub x4,x1,x5 -> launch1 = 1, launch2 = 0.
- lw x7,0(x2) issued at cycle 0 with LOAD_LAT = 2, then add x8,x7,x1 at head:
  - Cycles 1 and 2 -> sb_busy[7] = 1, launch1 = 0.
  - Cycle 3 -> launch1 = 1.
- Pair lw x3 then sw x4 -> launch2 = 0 (single LSU). Pair beq then add -> launch2 = 0. Pair add then beq -> launch2 = 1.
- flush = 1 or stall = 1 with valid pair -> launch1 = launch2 = 0. Set cnt[9] via load, then flush -> sb_busy[9] still counts down normally.
- rst asserted while cnt[5] = 2 -> next cycle sb_busy = 0 and head use of x5 issues. Also lw x0 -> sb_busy stays 0.
